// File: rtl/simon32_64_for.sv
// Simon 32/64 encryptor: 32 rounds unrolled combinationally, result registered.
// Round keys are derived from KEY at elaboration; a new block is accepted every clock.
module simon32_64_for #(
  parameter logic [63:0] KEY = 64'h1918_1110_0908_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] plaintext,
  output logic [31:0] ciphertext
);

  localparam int ROUNDS = 32;

  // z0 written i=0 first, so index 0 is the leftmost character
  localparam logic [0:61] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic [15:0] rol(input logic [15:0] v, input int j);
    return (v << j) | (v >> (16 - j));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int j);
    return (v >> j) | (v << (16 - j));
  endfunction

  function automatic logic [15:0] round_f(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [ROUNDS-1:0][15:0] gen_keys(input logic [63:0] key);
    logic [ROUNDS-1:0][15:0] k;
    logic [15:0]             t;
    k = '0;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 0; i < ROUNDS - 4; i++) begin
      t = ror(k[i+3], 3) ^ k[i+1];
      t = t ^ ror(t, 1);
      k[i+4] = ~k[i] ^ t ^ {15'b0, Z0[i]} ^ 16'h0003;
    end
    return k;
  endfunction

  localparam logic [ROUNDS-1:0][15:0] RK = gen_keys(KEY);

  logic [31:0] ct_p0;

  always_comb begin
    logic [15:0] x, y, tmp;
    x = plaintext[31:16];
    y = plaintext[15:0];
    for (int i = 0; i < ROUNDS; i++) begin
      tmp = x;
      x   = y ^ round_f(x) ^ RK[i];
      y   = tmp;
    end
    ct_p0 = {x, y};
  end

  // stage p0 -> registered output
  always_ff @(posedge clk) begin
    if (rst) ciphertext <= 32'h0;
    else     ciphertext <= ct_p0;
  end

endmodule

// File: tb/tb_simon32_64_for.sv
// Self-checking bench for simon32_64_for against a string-driven Simon 32/64 reference.
module tb_simon32_64_for;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] plaintext;
  logic [31:0] ciphertext;

  int pass_cnt = 0;
  int total_cnt = 0;

  string z0s = "11111010001001010110000111001101111101000100101011000011100110";
  bit [63:0] key = 64'h1918_1110_0908_0100;

  simon32_64_for dut (
    .clk(clk),
    .rst(rst),
    .plaintext(plaintext),
    .ciphertext(ciphertext)
  );

  always #50 clk = ~clk;

  function automatic bit [15:0] rl(bit [15:0] v, int j);
    return (v << j) | (v >> (16 - j));
  endfunction

  function automatic bit [31:0] simon_ref(bit [31:0] pt);
    bit [15:0] k [32];
    bit [15:0] t, x, y, nx;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = rl(k[i+3], 13) ^ k[i+1];
      t = t ^ rl(t, 15);
      k[i+4] = 16'hFFFC ^ k[i] ^ t ^ ((z0s[i] == 8'h31) ? 16'h1 : 16'h0);
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      nx = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
      y  = x;
      x  = nx;
    end
    return {x, y};
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    plaintext = $urandom;
    for (int e = 0; e < 2; e++) begin
      edge_sample();
      total_cnt++;
      if (ciphertext !== 32'h0)
        $display("FAIL reset: got %h want %h", ciphertext, 32'h0);
      else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    plaintext = $urandom;
    edge_sample();
    total_cnt++;
    if (ciphertext !== simon_ref(plaintext))
      $display("FAIL first_after_reset: got %h want %h", ciphertext, simon_ref(plaintext));
    else pass_cnt++;
  endtask

  task automatic test_vector();
    @(negedge clk);
    plaintext = 32'h6565_6877;
    edge_sample();
    total_cnt++;
    if (ciphertext !== 32'hC69B_E9BB)
      $display("FAIL std_vector: got %h want %h", ciphertext, 32'hC69B_E9BB);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit [31:0] pts [3] = '{32'h4142_4344, 32'h7768_6565, 32'h6565_6877};
    bit [31:0] prev_exp;
    @(negedge clk);
    plaintext = 32'h0;
    edge_sample();
    prev_exp = simon_ref(32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (ciphertext !== prev_exp)
        $display("FAIL b2b_hold%0d: got %h want %h", i, ciphertext, prev_exp);
      else pass_cnt++;
      plaintext = pts[i];
      edge_sample();
      prev_exp = (i == 2) ? 32'hC69B_E9BB : simon_ref(pts[i]);
      total_cnt++;
      if (ciphertext !== prev_exp)
        $display("FAIL b2b%0d: got %h want %h", i, ciphertext, prev_exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    bit [31:0] p = $urandom;
    @(negedge clk);
    plaintext = p;
    for (int e = 0; e < 5; e++) begin
      edge_sample();
      total_cnt++;
      if (ciphertext !== simon_ref(p))
        $display("FAIL hold%0d: got %h want %h", e, ciphertext, simon_ref(p));
      else pass_cnt++;
    end
  endtask

  task automatic test_midreset();
    bit [31:0] a = $urandom;
    bit [31:0] b = $urandom;
    @(negedge clk);
    plaintext = a;
    edge_sample();
    total_cnt++;
    if (ciphertext !== simon_ref(a))
      $display("FAIL mid_pre: got %h want %h", ciphertext, simon_ref(a));
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    plaintext = b;
    edge_sample();
    total_cnt++;
    if (ciphertext !== 32'h0)
      $display("FAIL mid_rst: got %h want %h", ciphertext, 32'h0);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    total_cnt++;
    if (ciphertext !== simon_ref(b))
      $display("FAIL mid_post: got %h want %h", ciphertext, simon_ref(b));
    else pass_cnt++;
  endtask

  task automatic test_corners();
    bit [31:0] c [2] = '{32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      plaintext = c[i];
      edge_sample();
      total_cnt++;
      if (ciphertext !== simon_ref(c[i]))
        $display("FAIL corner_%h: got %h want %h", c[i], ciphertext, simon_ref(c[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit [31:0] p;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      p = $urandom;
      plaintext = p;
      edge_sample();
      total_cnt++;
      if (ciphertext !== simon_ref(p))
        $display("FAIL random%0d pt=%h: got %h want %h", i, p, ciphertext, simon_ref(p));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    plaintext = 32'h0;
    test_reset();
    test_vector();
    test_back_to_back();
    test_hold();
    test_midreset();
    test_corners();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
